// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing for the monitor tester.
// Free-running pixel counters drive registered hsync/vsync, the active-video
// flag, the pixel coordinates and two one-clock strobes. All outputs come
// straight from flops that load on the same edge, so they have no skew
// between them.
// Optional feature: define VGA_CLK_DIV_EN so that a pixel tick happens once
// every CLK_DIV clocks. When it is undefined, every clock is a tick.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned CLK_DIV  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       hsync,
    output logic       vsync,
    output logic       canDisplayImage,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       pix_valid,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 11-bit copies of the region boundaries. A boundary can equal 1024,
    // which does not fit in the 10-bit counters.
    localparam logic [10:0] H_ACT_L = 11'(H_ACTIVE);
    localparam logic [10:0] H_SS_L  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SE_L  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_L = 11'(V_ACTIVE);
    localparam logic [10:0] V_SS_L  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SE_L  = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);

    // Refuse to build a mode that the 10-bit counters cannot hold.
    generate
        if (H_TOTAL > 1024 || H_TOTAL == 0) begin : g_h_total_bad
            $error("vga_timing_gen: H_TOTAL must be in 1..1024");
        end
        if (V_TOTAL > 1024 || V_TOTAL == 0) begin : g_v_total_bad
            $error("vga_timing_gen: V_TOTAL must be in 1..1024");
        end
        if (CLK_DIV == 0) begin : g_clk_div_bad
            $error("vga_timing_gen: CLK_DIV must be at least 1");
        end
    endgenerate

    logic tick;

`ifdef VGA_CLK_DIV_EN
    localparam int unsigned         DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;

    assign tick = (div_q == DIV_LAST);

    // Divider: count 0..CLK_DIV-1, then restart on the tick edge.
    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (tick) begin
            div_d = '0;
        end
    end

    // Divider register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    logic [9:0] hn_q, hn_d;
    logic [9:0] vn_q, vn_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       de_q, de_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       pv_q, pv_d;
    logic       fs_q, fs_d;

    logic       in_hsync;
    logic       in_vsync;

    assign in_hsync = ({1'b0, hn_q} >= H_SS_L) && ({1'b0, hn_q} < H_SE_L);
    assign in_vsync = ({1'b0, vn_q} >= V_SS_L) && ({1'b0, vn_q} < V_SE_L);

    // On a tick, present the pixel the counters point at, then step the counters.
    always_comb begin
        hn_d = hn_q;
        vn_d = vn_q;
        x_d  = x_q;
        y_d  = y_q;
        de_d = de_q;
        hs_d = hs_q;
        vs_d = vs_q;
        pv_d = tick;
        fs_d = 1'b0;
        if (tick) begin
            x_d  = hn_q;
            y_d  = vn_q;
            de_d = ({1'b0, hn_q} < H_ACT_L) && ({1'b0, vn_q} < V_ACT_L);
            hs_d = in_hsync ? SYNC_POL : ~SYNC_POL;
            vs_d = in_vsync ? SYNC_POL : ~SYNC_POL;
            fs_d = (hn_q == '0) && (vn_q == '0);
            if (hn_q == H_LAST) begin
                hn_d = '0;
                vn_d = (vn_q == V_LAST) ? '0 : vn_q + 10'd1;
            end else begin
                hn_d = hn_q + 10'd1;
            end
        end
    end

    // Counter and output registers. Reset leaves both syncs deasserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hn_q <= '0;
            vn_q <= '0;
            x_q  <= '0;
            y_q  <= '0;
            de_q <= 1'b0;
            hs_q <= ~SYNC_POL;
            vs_q <= ~SYNC_POL;
            pv_q <= 1'b0;
            fs_q <= 1'b0;
        end else begin
            hn_q <= hn_d;
            vn_q <= vn_d;
            x_q  <= x_d;
            y_q  <= y_d;
            de_q <= de_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            pv_q <= pv_d;
            fs_q <= fs_d;
        end
    end

    assign hsync           = hs_q;
    assign vsync           = vs_q;
    assign canDisplayImage = de_q;
    assign x               = x_q;
    assign y               = y_q;
    assign pix_valid       = pv_q;
    assign frame_start     = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen.
// Instance a uses the default 640x480 mode. It checks the reset state, the first
// pixel, one full line, the line period and an asynchronous reset in the middle
// of a frame. Instance b uses a tiny active-high mode, and a queue of expected
// pixels is checked against it over three whole frames.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst_a_n, rst_b_n;
    logic       hs_a, vs_a, de_a, pv_a, fs_a;
    logic [9:0] x_a, y_a;
    logic       hs_b, vs_b, de_b, pv_b, fs_b;
    logic [9:0] x_b, y_b;

    int checks   = 0;
    int failures = 0;

    vga_timing_gen dut_a (
        .clk             (clk),
        .rst_n           (rst_a_n),
        .hsync           (hs_a),
        .vsync           (vs_a),
        .canDisplayImage (de_a),
        .x               (x_a),
        .y               (y_a),
        .pix_valid       (pv_a),
        .frame_start     (fs_a)
    );

    vga_timing_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .SYNC_POL (1'b1)
    ) dut_b (
        .clk             (clk),
        .rst_n           (rst_b_n),
        .hsync           (hs_b),
        .vsync           (vs_b),
        .canDisplayImage (de_b),
        .x               (x_b),
        .y               (y_b),
        .pix_valid       (pv_b),
        .frame_start     (fs_b)
    );

    // Expected word for the small mode: {x, y, de, hsync, vsync, frame_start, pix_valid}
    logic [24:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_hsync"}, 32'(hs_a), 32'd1);
        chk({tag, "_vsync"}, 32'(vs_a), 32'd1);
        chk({tag, "_de"},    32'(de_a), 32'd0);
        chk({tag, "_x"},     32'(x_a),  32'd0);
        chk({tag, "_y"},     32'(y_a),  32'd0);
        chk({tag, "_pv"},    32'(pv_a), 32'd0);
        chk({tag, "_fs"},    32'(fs_a), 32'd0);
    endtask

    initial begin
        int t0;
        int hs_low;
        logic [24:0] e;

        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        repeat (5) @(negedge clk);

        // Reset state on both instances. In the small mode the syncs idle low.
        chk_reset_a("rst_a");
        chk("rst_b_hsync", 32'(hs_b), 32'd0);
        chk("rst_b_vsync", 32'(vs_b), 32'd0);
        chk("rst_b_de",    32'(de_b), 32'd0);
        chk("rst_b_pv",    32'(pv_b), 32'd0);

        // The first edge after release presents (0,0).
        rst_a_n = 1'b1;
        @(negedge clk);
        chk("first_x",  32'(x_a),  32'd0);
        chk("first_y",  32'(y_a),  32'd0);
        chk("first_de", 32'(de_a), 32'd1);
        chk("first_fs", 32'(fs_a), 32'd1);
        chk("first_pv", 32'(pv_a), 32'd1);
        chk("first_hs", 32'(hs_a), 32'd1);
        t0 = cyc;

        // Line 0, pixels 1..799.
        hs_low = 0;
        for (int i = 1; i < 800; i++) begin
            @(negedge clk);
            chk("line0_x",  32'(x_a),  32'(i));
            chk("line0_y",  32'(y_a),  32'd0);
            chk("line0_de", 32'(de_a), (i < 640) ? 32'd1 : 32'd0);
            chk("line0_hs", 32'(hs_a), (i >= 656 && i < 752) ? 32'd0 : 32'd1);
            chk("line0_fs", 32'(fs_a), 32'd0);
            chk("line0_pv", 32'(pv_a), 32'd1);
            if (hs_a == 1'b0) hs_low++;
        end
        chk("hs_low_count", 32'(hs_low), 32'd96);

        // Line 1 begins. The line period is 800 clocks.
        @(negedge clk);
        chk("line1_x",      32'(x_a),       32'd0);
        chk("line1_y",      32'(y_a),       32'd1);
        chk("line1_fs",     32'(fs_a),      32'd0);
        chk("line1_vs",     32'(vs_a),      32'd1);
        chk("line_period",  32'(cyc - t0),  32'd800);

        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            chk("line1_x", 32'(x_a), 32'(i));
            chk("line1_y", 32'(y_a), 32'd1);
        end

        // Assert reset with no clock edge in between. Outputs must clear at once.
        #1 rst_a_n = 1'b0;
        #1 chk_reset_a("async_rst");

        repeat (3) @(negedge clk);
        chk_reset_a("held_rst");
        rst_a_n = 1'b1;
        @(negedge clk);
        chk("rerel_x",  32'(x_a),  32'd0);
        chk("rerel_y",  32'(y_a),  32'd0);
        chk("rerel_de", 32'(de_a), 32'd1);
        chk("rerel_fs", 32'(fs_a), 32'd1);
        chk("rerel_pv", 32'(pv_a), 32'd1);
        @(negedge clk);
        chk("rerel2_x",  32'(x_a),  32'd1);
        chk("rerel2_fs", 32'(fs_a), 32'd0);

        // Small mode: 8 pixels per line, 6 lines per frame, three frames.
        for (int f = 0; f < 3; f++) begin
            for (int v = 0; v < 6; v++) begin
                for (int h = 0; h < 8; h++) begin
                    e = {10'(h), 10'(v),
                         1'((h < 4) && (v < 3)),
                         1'((h == 5) || (h == 6)),
                         1'(v == 4),
                         1'((h == 0) && (v == 0)),
                         1'b1};
                    exp_q.push_back(e);
                end
            end
        end
        rst_b_n = 1'b1;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            chk("small_pixel", 32'({x_b, y_b, de_b, hs_b, vs_b, fs_b, pv_b}), 32'(e));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Upstream raster timing stage for the monitor tester top level.
- Produces pixel-rate h/v counters, sync pulses, the active-video flag and pixel coordinates that the pattern generator and colour mux consume.
- Fully registered with zero skew between all outputs; timing comes from parameters, so other VESA modes need no RTL change.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted sync level (0 = active-low, 1 = active-high)
- CLK_DIV, 2, clk cycles per pixel; used only with the optional feature

Ports:
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- hsync  out  1  horizontal sync, polarity per SYNC_POL
- vsync  out  1  vertical sync, polarity per SYNC_POL
- canDisplayImage  out  1  high while the presented pixel is in the active region
- x  out  10  column of the presented pixel
- y  out  10  row of the presented pixel
- pix_valid  out  1  one-clk strobe: outputs changed on this edge
- frame_start  out  1  one-clk strobe when pixel (0,0) is presented

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both must be ≤1024; an elaboration-time check is required.
- Internal "next pixel" counters: hn in 0..H_TOTAL-1, vn in 0..V_TOTAL-1.
- Pixel tick: every clk by default; see Optional Feature.
- On each tick, present the next pixel, then advance:
  - Load x←hn, y←vn.
  - canDisplayImage ← (hn<H_ACTIVE && vn<V_ACTIVE).
  - hsync asserted iff H_ACTIVE+H_FP ≤ hn < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsync asserted iff V_ACTIVE+V_FP ≤ vn < V_ACTIVE+V_FP+V_SYNC (490..491). vsync is line-based and changes only when hn=0 is presented.
  - Advance hn. When hn=H_TOTAL-1, hn wraps to 0 and vn increments.
  - When vn=V_TOTAL-1 and hn=H_TOTAL-1, both wrap to 0 on the same edge.
- Between ticks, all outputs hold.
- pix_valid = 1 exactly on the clk following each tick edge: the first cycle the new values are visible.
- frame_start = 1 for that same single clk when the presented pixel is (0,0); otherwise 0.
- Latency: the first tick after reset release presents (0,0), with canDisplayImage=1 and frame_start=1.
- x and y present raw counter values in blanking (up to 799/524). Consumers qualify with canDisplayImage.
- Reset (async assert, sync-safe release): hn=vn=0, x=y=0, canDisplayImage=0, pix_valid=0, frame_start=0, hsync=vsync=~SYNC_POL (deasserted).
- Reset mid-frame forces the reset state immediately. The next frame after release starts at (0,0); no partial-line output is required.
- No other events: counters are free-running with no external stall.

Optional Feature:
- Macro: VGA_CLK_DIV_EN.
- Defined:
  - A divider counter runs 0..CLK_DIV-1 and resets to 0.
  - A tick fires on the edge where the divider equals CLK_DIV-1, so the first tick is CLK_DIV clk edges after reset release.
  - pix_valid is high 1 clk in CLK_DIV; outputs are stable for CLK_DIV clks.
  - Example: 50 MHz clk with CLK_DIV=2 yields a 25 MHz pixel rate.
  - CLK_DIV=1 must behave identically to the macro being undefined.
- Undefined:
  - No divider logic; every clk is a tick and CLK_DIV is ignored.

Test Plan:
- Reset: hold rst_n=0 for 5 clk → hsync=vsync=1, canDisplayImage=0, x=y=0, pix_valid=0, frame_start=0. Release with macro undefined → first edge gives x=0, y=0, canDisplayImage=1, frame_start=1.
- Line timing (defaults, no macro):
  - canDisplayImage high for x=0..639, low for 640..799.
  - hsync low exactly 96 clks, starting at x=656.
  - Consecutive x=0 presentations are 800 clks apart.
- Frame timing:
  - vsync low exactly for lines y=490,491 (1600 clks), asserting with x=0 of line 490.
  - frame_start period = 420000 clks.
  - y wraps 524→0 on the same edge that x wraps 799→0.
- Divider: with VGA_CLK_DIV_EN and CLK_DIV=2 → pix_valid every 2nd clk, outputs stable for 2 clks, frame_start period = 840000 clks. With CLK_DIV=3 → first tick 3 edges after release.
- Reset mid-frame: assert rst_n at x=300,y=200 → outputs return to reset values within the same cycle (async). After release, the next presented pixel is (0,0) with frame_start=1.
- Small mode, SYNC_POL=1: H=4/1/2/1, V=3/1/1/1 → line of 8 ticks with hsync high at x=5,6; frame of 6 lines with vsync high on y=4; canDisplayImage pattern checked by scoreboard over 3 frames.
